mem_io_bridge: RTL and testbench

//   Sits between the SLC-3 datapath/control and external async SRAM plus board I/O.

---
 rtl/mem_io_bridge.sv | 106 ++++++++++
 tb/tb_mem_io_bridge.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge.sv
// SLC-3 bridge between the datapath and async SRAM plus one memory-mapped I/O word.
// Serves one read or write per request; strobes are registered and glitch-free.
module mem_io_bridge #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Mem_Req,
   input  logic        Mem_WE,
   input  logic [15:0] MAR,
   input  logic [15:0] MDR,
   input  logic [9:0]  Switches,
   input  logic [15:0] SRAM_Data_In,
   output logic [15:0] MDR_In,
   output logic        Mem_Ready,
   output logic [19:0] SRAM_ADDR,
   output logic [15:0] SRAM_Data_Out,
   output logic        SRAM_Data_OE,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic [15:0] Hex_Out
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t     state, state_nx;
   logic [2:0] cnt, cnt_nx;
   logic       we_q;
   logic       accept, is_io, last;
   logic       acc_nx, wr_nx;

   // the Mem_Ready cycle still belongs to the completion handshake
   assign accept = (state == IDLE) && Mem_Req && !Mem_Ready;
   assign is_io  = (MAR == IO_ADDR);
   assign last   = (state == ACCESS) && (cnt == 3'd0);
   assign acc_nx = (state_nx == ACCESS);
   assign wr_nx  = accept ? Mem_WE : we_q;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (is_io) begin
                  state_nx = DONE;
               end else begin
                  state_nx = ACCESS;
                  cnt_nx   = 3'(WAIT_CYCLES);
               end
            end
         end
         ACCESS: begin
            if (cnt == 3'd0) state_nx = DONE;
            else             cnt_nx   = cnt - 3'd1;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // strobes follow the next state so they are low for exactly the ACCESS window
   always_ff @(posedge Clk) begin
      if (Reset) begin
         we_q          <= 1'b0;
         MDR_In        <= 16'h0000;
         Hex_Out       <= 16'h0000;
         Mem_Ready     <= 1'b0;
         SRAM_ADDR     <= 20'h00000;
         SRAM_Data_Out <= 16'h0000;
         SRAM_Data_OE  <= 1'b0;
         SRAM_CE_N     <= 1'b1;
         SRAM_OE_N     <= 1'b1;
         SRAM_WE_N     <= 1'b1;
      end else begin
         Mem_Ready    <= (state == DONE);
         SRAM_CE_N    <= !acc_nx;
         SRAM_OE_N    <= !(acc_nx && !wr_nx);
         SRAM_WE_N    <= !(acc_nx && wr_nx);
         SRAM_Data_OE <= acc_nx && wr_nx;
         if (accept) begin
            we_q          <= Mem_WE;
            SRAM_ADDR     <= {4'h0, MAR};
            SRAM_Data_Out <= MDR;
            if (is_io) begin
               if (Mem_WE) Hex_Out <= MDR;
               else        MDR_In  <= {6'b0, Switches};
            end
         end
         if (last && !we_q) MDR_In <= SRAM_Data_In;
      end
   end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: one instance with two wait cycles,
// one with zero wait cycles for back-to-back reads.
module tb_mem_io_bridge;

   typedef struct packed {
      logic [15:0] mdr;
      logic [15:0] hex;
   } exp_t;

   logic        Clk, Reset;
   logic [9:0]  sw;
   logic        req0, we0, req1, we1;
   logic [15:0] mar0, mdr0, mar1, mdr1;
   logic [15:0] din0, din1, MDR_In0, MDR_In1, Dout0, Dout1, Hex0, Hex1;
   logic [19:0] ADDR0, ADDR1;
   logic        Rdy0, Rdy1, DOE0, DOE1;
   logic        CE0, OE0, WE0, CE1, OE1, WE1;

   int   n_vec = 0;
   int   n_bad = 0;
   exp_t q0[$];
   logic [15:0] q1[$];
   logic [15:0] m_mdr, m_hex;

   function automatic logic [15:0] sram_f(input logic [15:0] a);
      return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'h5A5A);
   endfunction

   assign din0 = sram_f(ADDR0[15:0]);
   assign din1 = sram_f(ADDR1[15:0]);

   mem_io_bridge #(.WAIT_CYCLES(2), .IO_ADDR(16'hFFFF)) dut0 (
      .Clk(Clk), .Reset(Reset), .Mem_Req(req0), .Mem_WE(we0),
      .MAR(mar0), .MDR(mdr0), .Switches(sw), .SRAM_Data_In(din0),
      .MDR_In(MDR_In0), .Mem_Ready(Rdy0), .SRAM_ADDR(ADDR0),
      .SRAM_Data_Out(Dout0), .SRAM_Data_OE(DOE0), .SRAM_CE_N(CE0),
      .SRAM_OE_N(OE0), .SRAM_WE_N(WE0), .Hex_Out(Hex0)
   );

   mem_io_bridge #(.WAIT_CYCLES(0), .IO_ADDR(16'hFFFF)) dut1 (
      .Clk(Clk), .Reset(Reset), .Mem_Req(req1), .Mem_WE(we1),
      .MAR(mar1), .MDR(mdr1), .Switches(sw), .SRAM_Data_In(din1),
      .MDR_In(MDR_In1), .Mem_Ready(Rdy1), .SRAM_ADDR(ADDR1),
      .SRAM_Data_Out(Dout1), .SRAM_Data_OE(DOE1), .SRAM_CE_N(CE1),
      .SRAM_OE_N(OE1), .SRAM_WE_N(WE1), .Hex_Out(Hex1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // scoreboard pops on every completion pulse
   always @(negedge Clk) begin
      if (!Reset) begin
         if (Rdy0) begin
            if (q0.size() == 0) chk("spurious0", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = q0.pop_front();
               chk("mdr_in0", 32'(MDR_In0), 32'(e.mdr));
               chk("hex0", 32'(Hex0), 32'(e.hex));
            end
         end
         if (Rdy1) begin
            if (q1.size() == 0) chk("spurious1", 32'd1, 32'd0);
            else chk("mdr_in1", 32'(MDR_In1), 32'(q1.pop_front()));
         end
         if (!WE0 && !DOE0) chk("we_wo_oe0", 32'd1, 32'd0);
         if (!WE1 && !DOE1) chk("we_wo_oe1", 32'd1, 32'd0);
      end
   end

   task automatic access0(input logic w, input logic [15:0] a,
                          input logic [15:0] d, input bit poke);
      int  lat, ce_lo, oe_lo, we_lo;
      bit  seen, io;
      io = (a == 16'hFFFF);
      @(negedge Clk);
      we0 = w; mar0 = a; mdr0 = d; req0 = 1'b1;
      if (io) begin
         if (w) m_hex = d;
         else   m_mdr = {6'b0, sw};
      end else if (!w) begin
         m_mdr = sram_f(a);
      end
      q0.push_back('{m_mdr, m_hex});
      ce_lo = 0; oe_lo = 0; we_lo = 0; seen = 0; lat = 0;
      for (int i = 0; i <= 20 && !seen; i++) begin
         @(posedge Clk);
         #1;
         if (i == 0) req0 = 1'b0;
         if (!CE0) ce_lo++;
         if (!OE0 && ADDR0 == {4'h0, a}) oe_lo++;
         if (!WE0 && DOE0 && Dout0 == d && ADDR0 == {4'h0, a}) we_lo++;
         if (Rdy0) begin seen = 1; lat = i; end
         if (poke && i == 1) begin
            req0 = 1'b1; we0 = 1'b1; mar0 = 16'h0777;
         end
         if (poke && i == 2) req0 = 1'b0;
      end
      if (!seen) chk("timeout", 32'd0, 32'd1);
      else begin
         chk("latency", 32'(lat), io ? 32'd1 : 32'd4);
         @(posedge Clk);
         #1 chk("rdy_pulse", 32'(Rdy0), 32'd0);
      end
      chk("ce_lo", 32'(ce_lo), io ? 32'd0 : 32'd3);
      chk("oe_lo", 32'(oe_lo), (!io && !w) ? 32'd3 : 32'd0);
      chk("we_lo", 32'(we_lo), (!io && w) ? 32'd3 : 32'd0);
   endtask

   initial begin
      int          nrdy, last_c;
      logic [15:0] a1;
      Reset = 1'b1; sw = 10'h000;
      req0 = 0; we0 = 0; mar0 = 0; mdr0 = 0;
      req1 = 0; we1 = 0; mar1 = 0; mdr1 = 0;
      m_mdr = 16'h0; m_hex = 16'h0;
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_mdr", 32'(MDR_In0), 32'd0);
      chk("rst_hex", 32'(Hex0), 32'd0);
      chk("rst_rdy", 32'(Rdy0), 32'd0);
      chk("rst_strb", {29'd0, CE0, OE0, WE0}, 32'd7);
      chk("rst_addr", 32'(ADDR0), 32'd0);
      chk("rst_dout", {15'd0, DOE0, Dout0}, 32'd0);
      @(negedge Clk) Reset = 1'b0;

      access0(1'b0, 16'h1234, 16'h0000, 0);
      access0(1'b1, 16'h0040, 16'hA5A5, 0);
      access0(1'b0, 16'h0200, 16'h0000, 0);
      sw = 10'h3A5;
      access0(1'b0, 16'hFFFF, 16'h0000, 0);
      access0(1'b1, 16'hFFFF, 16'h00C7, 0);
      access0(1'b0, 16'h0300, 16'h0000, 1);
      repeat (4) @(posedge Clk);

      @(negedge Clk);
      a1 = 16'h2000; mar1 = a1; q1.push_back(sram_f(a1)); req1 = 1'b1;
      nrdy = 0; last_c = 0;
      for (int c = 1; c <= 40 && nrdy < 5; c++) begin
         @(posedge Clk);
         #1;
         if (Rdy1) begin
            if (nrdy > 0) chk("t6_period", 32'(c - last_c), 32'd4);
            last_c = c;
            nrdy++;
            a1 = a1 + 16'h0011;
            mar1 = a1;
            if (nrdy < 5) q1.push_back(sram_f(a1));
         end
      end
      req1 = 1'b0;
      chk("t6_count", 32'(nrdy), 32'd5);
      repeat (4) @(posedge Clk);

      @(negedge Clk);
      mar0 = 16'h0100; we0 = 1'b0; req0 = 1'b1;
      @(posedge Clk);
      #1 req0 = 1'b0;
      chk("mid_ce", 32'(CE0), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      q0.delete(); m_mdr = 16'h0; m_hex = 16'h0;
      @(posedge Clk);
      #1;
      chk("mid_strb", {29'd0, CE0, OE0, WE0}, 32'd7);
      chk("mid_rdy", 32'(Rdy0), 32'd0);
      chk("mid_mdr", 32'(MDR_In0), 32'd0);
      chk("mid_hex", 32'(Hex0), 32'd0);
      chk("mid_doe", 32'(DOE0), 32'd0);
      @(negedge Clk);
      mar0 = 16'hFFFF; we0 = 1'b1; mdr0 = 16'h1111; req0 = 1'b1;
      @(posedge Clk);
      #1 chk("rst_drop_hex", 32'(Hex0), 32'd0);
      @(negedge Clk);
      req0 = 1'b0; Reset = 1'b0;
      repeat (6) @(posedge Clk);
      #1;
      chk("post_rdy", 32'(Rdy0), 32'd0);
      chk("q0_empty", 32'(q0.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
